// File: rtl/line_window_ctrl.sv
// Line-buffer window controller: sequences shared RAM read/write per pixel and emits window coordinates.
// Optional macro LINE_WINDOW_CTRL_BORDER_EN emits border-overlapping windows too, flagged on border_o.
module line_window_ctrl #(
  parameter int LINE_W_P = 640,
  parameter int LINE_H_P = 480
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  input  logic                        sof_i,
  output logic                        ready_o,
  output logic [$clog2(LINE_W_P)-1:0] ram_addr_o,
  output logic                        ram_wr_en_o,
  output logic                        ram_rd_en_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(LINE_H_P)-1:0] row_o,
  output logic [$clog2(LINE_W_P)-1:0] col_o,
  output logic                        last_o,
  output logic                        border_o
);

  localparam int ADDR_W = $clog2(LINE_W_P);
  localparam int ROW_W  = $clog2(LINE_H_P);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_W_P - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(LINE_H_P - 1);
  localparam logic [ADDR_W-1:0] COL_TWO  = ADDR_W'(2);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0]  ROW_TWO  = ROW_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic                valid_q, valid_d;
  logic [ROW_W-1:0]    orow_q, orow_d;
  logic [ADDR_W-1:0]   ocol_q, ocol_d;
  logic                last_q, last_d;
  logic                border_q, border_d;

  logic                accept;
  logic                processed;
  logic [ROW_W-1:0]    pix_row;
  logic [ADDR_W-1:0]   pix_col;
  logic                col_end;
  logic                row_end;
  logic                emit;
  logic                pix_border;

  assign ready_o = !valid_q || ready_i;

  always_comb begin
    accept    = valid_i && ready_o;
    // In IDLE only a start-of-frame pixel is processed; everything else is dropped.
    processed = accept && ((state_q != IDLE) || sof_i);
    pix_row   = sof_i ? '0 : row_q;
    pix_col   = sof_i ? '0 : col_q;
    col_end   = (pix_col == COL_LAST);
    row_end   = (pix_row == ROW_LAST);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (processed) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : pix_row + ROW_ONE;
      end else begin
        col_d = pix_col + ADDR_W'(1);
        row_d = pix_row;
      end
      unique case (state_q)
        IDLE:   state_d = PRIME;
        PRIME:  if (!sof_i && (pix_row == ROW_ONE) && col_end) state_d = STREAM;
        STREAM: if (sof_i || (row_end && col_end)) state_d = PRIME;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef LINE_WINDOW_CTRL_BORDER_EN
    emit       = processed;
    pix_border = (pix_row < ROW_TWO) || (pix_col < COL_TWO);
`else
    emit       = processed && (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
    pix_border = 1'b0;
`endif
  end

  // An emit implies an accept, which implies the previous window was consumed or absent.
  always_comb begin
    valid_d  = valid_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    last_d   = last_q;
    border_d = border_q;
    if (emit) begin
      valid_d  = 1'b1;
      orow_d   = pix_row;
      ocol_d   = pix_col;
      last_d   = row_end && col_end;
      border_d = pix_border;
    end else if (ready_i) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      orow_q   <= '0;
      ocol_q   <= '0;
      last_q   <= 1'b0;
      border_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      valid_q  <= valid_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
      last_q   <= last_d;
      border_q <= border_d;
    end
  end

  assign ram_addr_o  = pix_col;
  assign ram_wr_en_o = processed;
  assign ram_rd_en_o = processed;
  assign valid_o     = valid_q;
  assign row_o       = orow_q;
  assign col_o       = ocol_q;
  assign last_o      = last_q;
  assign border_o    = border_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl (8x6 frames) against a frame-position reference model.
module tb_line_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
`ifdef LINE_WINDOW_CTRL_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       valid_i, sof_i, ready_i;
  logic       ready_o, ram_wr_en_o, ram_rd_en_o, valid_o, last_o, border_o;
  logic [2:0] ram_addr_o, col_o, row_o;

  line_window_ctrl #(.LINE_W_P(W), .LINE_H_P(H)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .valid_i     (valid_i),
    .sof_i       (sof_i),
    .ready_o     (ready_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wr_en_o (ram_wr_en_o),
    .ram_rd_en_o (ram_rd_en_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .row_o       (row_o),
    .col_o       (col_o),
    .last_o      (last_o),
    .border_o    (border_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sync flag plus linear position within the frame.
  bit m_sync;
  int m_pos;
  bit m_valid;
  int m_row, m_col;
  bit m_last, m_border;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt, hs_border, hs_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_pos = 0; m_valid = 0;
    m_row = 0; m_col = 0; m_last = 0; m_border = 0;
  endtask

  function automatic int win_count(input int n);
    int c = 0;
    for (int p = 0; p < n; p++)
      if (BORDER || ((p / W) >= 2 && (p % W) >= 2)) c++;
    return c;
  endfunction

  task automatic step(input bit v, input bit s, input bit r, output bit acc);
    bit proc, win;
    int pr, pc;
    @(negedge clk);
    valid_i = v; sof_i = s; ready_i = r;
    #1;
    acc  = v && (!m_valid || r);
    proc = acc && (m_sync || s);
    win  = 0;
    chk("ready_o", {31'd0, ready_o}, {31'd0, !m_valid || r});
    chk("ram_wr_en", {31'd0, ram_wr_en_o}, {31'd0, proc});
    chk("ram_rd_en", {31'd0, ram_rd_en_o}, {31'd0, proc});
    if (valid_o === 1'b1 && r) begin
      hs_cnt++;
      if (border_o) hs_border++;
      if (last_o) hs_last++;
    end
    if (proc) begin
      if (s) begin m_sync = 1; m_pos = 0; end
      pr = m_pos / W;
      pc = m_pos % W;
      chk("ram_addr", {29'd0, ram_addr_o}, pc);
      win = BORDER || (pr >= 2 && pc >= 2);
    end
    if (win) begin
      m_valid = 1; m_row = pr; m_col = pc;
      m_last = (m_pos == N - 1);
      m_border = (pr < 2 || pc < 2);
    end else if (r) begin
      m_valid = 0;
    end
    if (proc) m_pos = (m_pos + 1) % N;
    @(posedge clk);
    #1;
    chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    chk("row_o", {29'd0, row_o}, m_row);
    chk("col_o", {29'd0, col_o}, m_col);
    chk("last_o", {31'd0, last_o}, {31'd0, m_last});
    chk("border_o", {31'd0, border_o}, {31'd0, m_border});
  endtask

  task automatic feed(input int n, input bit sof_first, input int gap_pct, input int stall_pct);
    bit acc, v, r;
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int t = 0; t < 64 && !acc; t++) begin
        v = ($urandom_range(0, 99) >= gap_pct);
        r = ($urandom_range(0, 99) >= stall_pct);
        step(v, sof_first && (i == 0), r, acc);
      end
      chk("accept_bound", {31'd0, acc}, 32'd1);
    end
  endtask

  task automatic drain();
    bit acc;
    repeat (3) step(1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic clear_counts();
    hs_cnt = 0; hs_border = 0; hs_last = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_row"}, {29'd0, row_o}, 32'd0);
    chk({tag, "_col"}, {29'd0, col_o}, 32'd0);
    chk({tag, "_last"}, {31'd0, last_o}, 32'd0);
    chk({tag, "_border"}, {31'd0, border_o}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, ram_wr_en_o}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, ram_rd_en_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    bit acc;
    valid_i = 0; sof_i = 0; ready_i = 1;
    rstn = 0;
    model_reset();
    clear_counts();

    // Reset state, with valid pixels being offered while reset is held.
    #2;
    valid_i = 1;
    chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    @(negedge clk);
    valid_i = 0;
    rstn = 1;

    // Pixels without start-of-frame are dropped in IDLE.
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, acc);
    chk("idle_windows", hs_cnt, 0);

    // One full frame, no stalls.
    clear_counts();
    feed(N, 1'b1, 0, 0);
    drain();
    chk("frame_windows", hs_cnt, win_count(N));
    chk("frame_last", hs_last, 1);
    chk("frame_border", hs_border, BORDER ? 24 : 0);

    // Downstream stall of 5 cycles mid-frame.
    clear_counts();
    feed(21, 1'b1, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, acc);
    feed(N - 21, 1'b0, 0, 0);
    drain();
    chk("stall_windows", hs_cnt, win_count(N));
    chk("stall_last", hs_last, 1);

    // Resync at (3,4): abandoned frame gives no last_o.
    clear_counts();
    feed(28, 1'b1, 0, 0);
    feed(N, 1'b1, 25, 25);
    drain();
    chk("resync_windows", hs_cnt, win_count(28) + win_count(N));
    chk("resync_last", hs_last, 1);

    // Asynchronous reset between clock edges mid-frame.
    feed(20, 1'b1, 0, 0);
    @(posedge clk);
    #3;
    valid_i = 0;
    rstn = 0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rstn = 1;
    clear_counts();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, acc);
    chk("post_rst_drop", hs_cnt, 0);
    feed(N, 1'b1, 0, 0);
    drain();
    chk("post_rst_windows", hs_cnt, win_count(N));

    // Randomised traffic over back-to-back continuous frames.
    clear_counts();
    feed(3 * N, 1'b0, 30, 30);
    drain();
    chk("random_windows", hs_cnt, 3 * win_count(N));
    chk("random_last", hs_last, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_window_ctrl.md
LINE_WINDOW_CTRL -- requirements
Module: line_window_ctrl

Interface
REQ-001 SHALL have parameter LINE_W_P, default 640, meaning pixels per line, at least 3.
REQ-002 SHALL have parameter LINE_H_P, default 480, meaning lines per frame, at least 3.
REQ-003 SHALL define ADDR_W = ceil(log2(LINE_W_P)) as a localparam.
REQ-004 clk_i  in  1  single clock; all logic is rising-edge.
REQ-005 rstn_i  in  1  asynchronous, active-low reset.
REQ-006 valid_i  in  1  upstream pixel valid.
REQ-007 sof_i  in  1  start-of-frame marker, qualified by valid_i.
REQ-008 ready_o  out  1  upstream ready.
REQ-009 ram_addr_o  out  ADDR_W  shared read/write address to the line-buffer RAMs.
REQ-010 ram_wr_en_o, ram_rd_en_o  out  1 each  line-buffer RAM write/read enables.
REQ-011 valid_o  out  1  window valid, registered.
REQ-012 ready_i  in  1  downstream ready.
REQ-013 row_o  out  ceil(log2(LINE_H_P))  row of the pixel at the window's bottom-right.
REQ-014 col_o  out  ADDR_W  column of the pixel at the window's bottom-right.
REQ-015 last_o  out  1  marks the final window of the frame.
REQ-016 border_o  out  1  window overlaps the frame edge.

Function
REQ-017 The accept condition SHALL be accept = valid_i && ready_o.
REQ-018 ready_o SHALL equal (!valid_o || ready_i), combinationally.
REQ-019 The FSM SHALL have states IDLE, PRIME and STREAM, and SHALL reset to IDLE.
REQ-020 IDLE: accepts with sof_i=0 SHALL be dropped, with no RAM enables and no counter change.
REQ-021 IDLE: an accept with sof_i=1 SHALL be processed as pixel (row 0, col 0), then the FSM SHALL go to PRIME.
REQ-022 On every processed accept, ram_rd_en_o and ram_wr_en_o SHALL both be 1 in the same cycle, with ram_addr_o = col.
REQ-023 The RAM is read-before-write with 1-cycle read latency; with no processed accept, both enables SHALL be 0.
REQ-024 The column counter SHALL increment per processed accept and wrap at LINE_W_P-1 to 0, incrementing row on the wrap.
REQ-025 PRIME SHALL go to STREAM on the accept of (row 1, col LINE_W_P-1).
REQ-026 On the accept of (LINE_H_P-1, LINE_W_P-1), row and col SHALL clear and the FSM SHALL go to PRIME (continuous frames; IDLE is re-entered only by reset).
REQ-027 An accept with sof_i=1 in PRIME or STREAM SHALL resynchronise: the pixel becomes (0,0), the FSM goes to PRIME, and the previous frame is abandoned with no last_o.
REQ-028 A window SHALL be emitted for a processed accept when its row >= 2 and col >= 2.
REQ-029 valid_o SHALL rise the cycle after the accept, with row_o and col_o set to that pixel's coordinates.
REQ-030 last_o SHALL be 1 only with the window at (LINE_H_P-1, LINE_W_P-1).
REQ-031 While valid_o && !ready_i, valid_o, row_o, col_o, last_o and border_o SHALL hold; no accept occurs, so no window is lost.
REQ-032 valid_o SHALL clear after a handshake when no new window is produced that cycle.

Reset
REQ-033 On rstn_i low, the block SHALL asynchronously clear state to IDLE, the counters to 0, and valid_o, row_o, col_o, last_o and border_o to 0.
REQ-034 On rstn_i low, ram_wr_en_o and ram_rd_en_o SHALL be 0, and ready_o SHALL be 1.
REQ-035 Reset SHALL NOT clear RAM contents; stale lines are harmless because PRIME suppresses windows.

Configuration
REQ-036 The macro LINE_WINDOW_CTRL_BORDER_EN SHALL compile the border-window feature in or out.
REQ-037 With LINE_WINDOW_CTRL_BORDER_EN defined, a window SHALL be emitted for every processed accept, with border_o = (row < 2 || col < 2).
REQ-038 Without LINE_WINDOW_CTRL_BORDER_EN, only interior windows SHALL be emitted (REQ-028), and border_o SHALL be tied to 0.

Verification
All scenarios use LINE_W_P=8 and LINE_H_P=6.
REQ-039 Reset, then 48 pixels with sof_i on the first and ready_i=1 -> 24 valid_o pulses; the first has (2,2), one cycle after the 19th accept; the last has (5,7) with last_o=1.
REQ-040 Reset, then 10 pixels with sof_i=0 -> no RAM enables, no valid_o, FSM stays in IDLE.
REQ-041 Mid-STREAM, ready_i held 0 for 5 cycles -> ready_o=0, outputs stable, no RAM enables; the full frame still yields 24 windows.
REQ-042 sof_i asserted at (3,4) -> the next output coordinate restarts at (2,2) after 19 further accepts; no last_o for the abandoned frame.
REQ-043 rstn_i low mid-frame, asynchronously between clock edges -> all outputs 0 immediately; after release, pixels are dropped until sof_i.
REQ-044 With LINE_WINDOW_CTRL_BORDER_EN defined, a 48-pixel frame -> 48 valid_o pulses, with border_o=1 on exactly 24.
